fetch_m: RTL and testbench

FETCH_M -- requirements
Module: fetch_m

---
 rtl/fetch_m.sv | 122 ++++++++++++
 tb/tb_fetch_m.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/fetch_m.sv
// Instruction fetch stage: one outstanding memory request, single-entry output
// buffer toward decode, redirect override and sticky timeout fault.
module fetch_m #(
   parameter int                  ADDR_W   = 32,
   parameter int                  INSTR_W  = 32,
   parameter logic [ADDR_W-1:0]   RESET_PC = 32'h0,
   parameter logic [INSTR_W-1:0]  ILLEGAL  = 32'h0,
   parameter int                  TIMEOUT  = 16
) (
   input  logic               clk,
   input  logic               arst_n,
   input  logic               srst,
   output logic               im_req,
   output logic [ADDR_W-1:0]  im_addr,
   input  logic               im_ready,
   input  logic [INSTR_W-1:0] im_instr,
   input  logic               redirect,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instr,
   output logic [ADDR_W-1:0]  out_pc,
   output logic               out_illegal,
   output logic               fault
);

   typedef enum logic [1:0] {IDLE, REQ, HOLD, FAULT} state_t;

   localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

   state_t               state, state_n;
   logic [ADDR_W-1:0]    pc, pc_n;
   logic [ADDR_W-1:0]    opc_n;
   logic [INSTR_W-1:0]   oinstr_n;
   logic                 ovalid_n, oill_n, fault_n;
   logic [15:0]          cnt, cnt_n;

   assign im_req  = (state == REQ);
   assign im_addr = pc;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state       <= IDLE;
         pc          <= RESET_PC;
         out_valid   <= 1'b0;
         out_instr   <= ILLEGAL;
         out_pc      <= RESET_PC;
         out_illegal <= 1'b0;
         fault       <= 1'b0;
         cnt         <= '0;
      end else begin
         state       <= state_n;
         pc          <= pc_n;
         out_valid   <= ovalid_n;
         out_instr   <= oinstr_n;
         out_pc      <= opc_n;
         out_illegal <= oill_n;
         fault       <= fault_n;
         cnt         <= cnt_n;
      end
   end

   always_comb begin
      state_n  = state;
      pc_n     = pc;
      ovalid_n = out_valid;
      oinstr_n = out_instr;
      opc_n    = out_pc;
      oill_n   = out_illegal;
      fault_n  = fault;
      cnt_n    = cnt;
      if (srst) begin
         state_n  = IDLE;
         pc_n     = RESET_PC;
         ovalid_n = 1'b0;
         oinstr_n = ILLEGAL;
         opc_n    = RESET_PC;
         oill_n   = 1'b0;
         fault_n  = 1'b0;
         cnt_n    = '0;
      end else if (redirect && state != IDLE) begin
         // redirect wins over any same-cycle memory response or decode handshake
         state_n  = REQ;
         pc_n     = redirect_pc;
         ovalid_n = 1'b0;
         fault_n  = 1'b0;
         cnt_n    = '0;
      end else begin
         unique case (state)
            IDLE: begin
               state_n = REQ;
               cnt_n   = '0;
            end
            REQ: begin
               if (im_ready) begin
                  state_n  = HOLD;
                  oinstr_n = im_instr;
                  opc_n    = pc;
                  oill_n   = (im_instr == ILLEGAL);
                  pc_n     = pc + ADDR_W'(4);
                  ovalid_n = 1'b1;
               end else if (cnt == CNT_LAST) begin
                  state_n = FAULT;
                  fault_n = 1'b1;
               end else begin
                  cnt_n = cnt + 16'd1;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state_n  = REQ;
                  ovalid_n = 1'b0;
                  cnt_n    = '0;
               end
            end
            FAULT: ;
            default: state_n = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_m.sv
// Bench for fetch_m: directed scenarios plus random traffic, all outputs
// compared every cycle against a behavioural model of the fetch stage.
module tb_fetch_m;

   localparam int          TO   = 4;
   localparam logic [31:0] RPC  = 32'h0;
   localparam logic [31:0] ILL  = 32'h0;

   logic        clk = 1'b0;
   logic        arst_n, srst;
   logic        im_req, im_ready, redirect, out_valid, out_ready, out_illegal, fault;
   logic [31:0] im_addr, im_instr, redirect_pc, out_instr, out_pc;

   int ncmp = 0;
   int nfail = 0;

   // model: what the fetch stage is doing, as plain booleans
   bit          m_idle, m_fetch, m_hold, m_fault;
   logic [31:0] m_pc, m_instr, m_opc;
   bit          m_ill;
   int          m_wait;

   fetch_m #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(RPC), .ILLEGAL(ILL), .TIMEOUT(TO)) dut (
      .clk(clk), .arst_n(arst_n), .srst(srst),
      .im_req(im_req), .im_addr(im_addr), .im_ready(im_ready), .im_instr(im_instr),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
      .out_pc(out_pc), .out_illegal(out_illegal), .fault(fault)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_idle = 1; m_fetch = 0; m_hold = 0; m_fault = 0;
      m_pc = RPC; m_instr = ILL; m_opc = RPC; m_ill = 0; m_wait = 0;
   endtask

   task automatic model_step(input logic rdy, input logic [31:0] ins, input logic ordy,
                             input logic rd, input logic [31:0] rp, input logic sr);
      if (sr) model_reset();
      else if (!m_idle && rd) begin
         m_pc = rp; m_hold = 0; m_fetch = 1; m_fault = 0; m_wait = 0;
      end else if (m_idle) begin
         m_idle = 0; m_fetch = 1; m_wait = 0;
      end else if (m_fetch) begin
         if (rdy) begin
            m_instr = ins; m_opc = m_pc; m_ill = (ins == ILL);
            m_pc = m_pc + 32'd4; m_fetch = 0; m_hold = 1;
         end else if (m_wait + 1 == TO) begin
            m_fetch = 0; m_fault = 1;
         end else m_wait++;
      end else if (m_hold && ordy) begin
         m_hold = 0; m_fetch = 1; m_wait = 0;
      end
   endtask

   task automatic check_all();
      chk("im_req", im_req, m_fetch);
      chk("im_addr", im_addr, m_pc);
      chk("out_valid", out_valid, m_hold);
      chk("out_instr", out_instr, m_instr);
      chk("out_pc", out_pc, m_opc);
      chk("out_illegal", out_illegal, m_ill);
      chk("fault", fault, m_fault);
   endtask

   task automatic cyc(input logic rdy, input logic [31:0] ins, input logic ordy,
                      input logic rd, input logic [31:0] rp, input logic sr);
      im_ready = rdy; im_instr = ins; out_ready = ordy;
      redirect = rd; redirect_pc = rp; srst = sr;
      #1;
      check_all();
      @(posedge clk);
      model_step(rdy, ins, ordy, rd, rp, sr);
      #1;
   endtask

   initial begin
      arst_n = 1'b0; srst = 1'b0; im_ready = 1'b0; im_instr = '0;
      redirect = 1'b0; redirect_pc = '0; out_ready = 1'b0;
      model_reset();
      #12;
      check_all();
      @(posedge clk); #1;
      arst_n = 1'b1;

      // streaming with memory and decode always ready
      for (int i = 0; i < 9; i++) cyc(1, 32'h1000 + i, 1, 0, 0, 0);

      // srst, then hold an instruction with decode stalled
      cyc(0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 0);
      cyc(1, 32'h00500093, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) cyc(0, $urandom, 0, 0, 0, 0);
      chk("hold_instr", out_instr, 32'h00500093);
      chk("hold_noreq", im_req, 1'b0);
      chk("hold_pc", im_addr, 32'h4);
      cyc(0, 0, 1, 0, 0, 0);

      // memory timeout, then recover by redirect
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0);
      chk("fault_set", fault, 1'b1);
      cyc(0, 0, 0, 0, 0, 0);
      chk("fault_noreq", im_req, 1'b0);
      cyc(0, 0, 0, 1, 32'h100, 0);
      chk("fault_clr", fault, 1'b0);
      chk("redir_addr", im_addr, 32'h100);

      // redirect coincident with a response at pc=8
      cyc(0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 12 && !(m_fetch && m_pc == 32'h8); i++)
         cyc(1, $urandom, 1, 0, 0, 0);
      chk("reach_pc8", {im_req, im_addr}, {1'b1, 32'h8});
      cyc(1, 32'hDEAD_BEEF, 1, 1, 32'h200, 0);
      chk("drop_addr", im_addr, 32'h200);
      chk("drop_valid", out_valid, 1'b0);

      // pc wrap with an illegal instruction
      cyc(0, 0, 0, 1, 32'hFFFF_FFFC, 0);
      cyc(1, 32'h0, 0, 0, 0, 0);
      chk("wrap_ill", out_illegal, 1'b1);
      chk("wrap_opc", out_pc, 32'hFFFF_FFFC);
      chk("wrap_addr", im_addr, 32'h0);

      // random traffic
      for (int i = 0; i < 500; i++)
         cyc($urandom_range(0, 2) != 0, ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom,
             $urandom_range(0, 2) != 0, $urandom_range(0, 9) == 0,
             {$urandom_range(0, 255), 2'b00}, $urandom_range(0, 60) == 0);

      // async reset pulse while holding an instruction
      cyc(0, 0, 0, 1, 32'h40, 0);
      cyc(1, 32'h1234_5678, 0, 0, 0, 0);
      chk("pre_arst_valid", out_valid, 1'b1);
      #2 arst_n = 1'b0;
      #1;
      model_reset();
      chk("arst_valid", out_valid, 1'b0);
      chk("arst_addr", im_addr, RPC);
      check_all();
      #2 arst_n = 1'b1;
      for (int i = 0; i < 4; i++) cyc(1, 32'hABCD_0000 + i, 1, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
